// File: rtl/diferential_muxpga_fabric_if.sv
// Bus bundle for diferential_muxpga_fabric: fabric data path, run control and
// the serial configuration port.
//   data_in   : row-0 "up" inputs, column c at [c*B+B-1:c*B]
//   data_out  : bottom-row cell registers, same column packing
//   run       : 1 lets cell registers update, 0 holds them
//   cfg_en/cfg_in/cfg_load : scan shift enable, serial bit, commit request
//   cfg_out/cfg_full/cfg_err : chain MSB, chain-full flag, sticky early-commit error
// master drives the fabric (pin wrapper / bench), slave is the fabric itself.
interface diferential_muxpga_fabric_if #(
  parameter int unsigned COLS = 3,
  parameter int unsigned B    = 4
);
  logic [COLS*B-1:0] data_in;
  logic [COLS*B-1:0] data_out;
  logic              run;
  logic              cfg_en;
  logic              cfg_in;
  logic              cfg_load;
  logic              cfg_out;
  logic              cfg_full;
  logic              cfg_err;

  modport master (
    output data_in, run, cfg_en, cfg_in, cfg_load,
    input  data_out, cfg_out, cfg_full, cfg_err
  );

  modport slave (
    input  data_in, run, cfg_en, cfg_in, cfg_load,
    output data_out, cfg_out, cfg_full, cfg_err
  );
endinterface

// File: rtl/diferential_muxpga_fabric.sv
// ROWS x COLS grid of B-bit registered logic cells with per-cell configuration.
// Configuration is shifted serially into a shadow chain and committed to the
// active configuration in one cycle, so the fabric keeps running while a new
// image is being loaded.
// Ports:
//   clk     : fabric and configuration clock
//   reset_n : asynchronous active-low reset
//   bus     : diferential_muxpga_fabric_if.slave (data, run and config port)
// Cell k = row*COLS+col owns chain bits [8k+7:8k]:
//   [1:0] sel1, [3:2] sel2, [5:4] func, [6] hold, [7] reserved.
module diferential_muxpga_fabric #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 3,
  parameter int unsigned B    = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  diferential_muxpga_fabric_if.slave bus
);
  localparam int unsigned CELL_CFG_BITS = 8;
  localparam int unsigned CHAIN_LEN     = ROWS * COLS * CELL_CFG_BITS;
  localparam int unsigned CNT_W         = $clog2(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] chain_q, chain_d;
  logic [CHAIN_LEN-1:0] act_q, act_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 full;
  logic [B-1:0]         cell_q [ROWS][COLS];
  logic [B-1:0]         cell_d [ROWS][COLS];

  function automatic logic [B-1:0] pick(input logic [1:0] sel,
                                        input logic [B-1:0] up,
                                        input logic [B-1:0] upl,
                                        input logic [B-1:0] lf,
                                        input logic [B-1:0] rt);
    case (sel)
      2'd0:    return up;
      2'd1:    return upl;
      2'd2:    return lf;
      default: return rt;
    endcase
  endfunction

  // Scan chain, shift counter and commit.
  always_comb begin
    full    = (cnt_q == CNT_W'(CHAIN_LEN));
    chain_d = chain_q;
    act_d   = act_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (bus.cfg_en) begin
      chain_d = {chain_q[CHAIN_LEN-2:0], bus.cfg_in};
    end
    if (bus.cfg_load && full) begin
      // Commit takes the chain as it stood before this cycle's shift; a
      // simultaneous shift counts as the first bit of the next image.
      act_d = chain_q;
      cnt_d = bus.cfg_en ? CNT_W'(1) : '0;
    end else begin
      if (bus.cfg_en && !full) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (bus.cfg_load) begin
        err_d = 1'b1;
      end
    end
  end

  // Cell next-state. Neighbours are always registered q, with column
  // wrap-around; row 0 takes "up" and "up-left" from data_in instead of
  // wrapping to the bottom row.
  always_comb begin
    logic [CELL_CFG_BITS-1:0] cfg;
    logic [B-1:0]             up, upl, lf, rt, in1, in2, res;
    int unsigned              cl, cr;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        cl  = (c + COLS - 1) % COLS;
        cr  = (c + 1) % COLS;
        cfg = act_q[(r*COLS + c)*CELL_CFG_BITS +: CELL_CFG_BITS];
        if (r == 0) begin
          up  = bus.data_in[c*B +: B];
          upl = bus.data_in[cl*B +: B];
        end else begin
          up  = cell_q[r-1][c];
          upl = cell_q[r-1][cl];
        end
        lf  = cell_q[r][cl];
        rt  = cell_q[r][cr];
        in1 = pick(cfg[1:0], up, upl, lf, rt);
        in2 = pick(cfg[3:2], up, upl, lf, rt);
        case (cfg[5:4])
          2'd0:    res = in1 | in2;
          2'd1:    res = in1 & in2;
          2'd2:    res = in1 ^ in2;
          default: res = in1;
        endcase
        cell_d[r][c] = (bus.run && !cfg[6]) ? res : cell_q[r][c];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= '0;
      act_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          cell_q[r][c] <= '0;
        end
      end
    end else begin
      chain_q <= chain_d;
      act_q   <= act_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          cell_q[r][c] <= cell_d[r][c];
        end
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      bus.data_out[c*B +: B] = cell_q[ROWS-1][c];
    end
  end

  always_comb begin
    bus.cfg_out  = chain_q[CHAIN_LEN-1];
    bus.cfg_full = full;
    bus.cfg_err  = err_q;
  end
endmodule

// File: tb/tb_diferential_muxpga_fabric.sv
// Directed bench for diferential_muxpga_fabric (4x3 grid, 4-bit cells).
module tb_diferential_muxpga_fabric;
  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 3;
  localparam int unsigned B    = 4;
  localparam int unsigned CLEN = ROWS * COLS * 8;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  diferential_muxpga_fabric_if #(.COLS(COLS), .B(B)) bus ();

  diferential_muxpga_fabric #(.ROWS(ROWS), .COLS(COLS), .B(B)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    bus.cfg_en = 1'b1;
    bus.cfg_in = b;
    step();
    bus.cfg_en = 1'b0;
  endtask

  task automatic load_cfg(input logic [CLEN-1:0] img);
    for (int i = CLEN - 1; i >= 0; i--) shift_bit(img[i]);
  endtask

  task automatic commit();
    bus.cfg_load = 1'b1;
    step();
    bus.cfg_load = 1'b0;
  endtask

  logic [CLEN-1:0] cfg_x, cfg_y, cfg_w;
  logic [11:0]     exp_xor  [5];
  logic [11:0]     exp_hold [5];
  logic [11:0]     exp_wrap [6];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_xor  = '{12'h0AA, 12'hA0A, 12'hAA0, 12'h635, 12'h635};
    exp_hold = '{12'h356, 12'h563, 12'h665, 12'h967, 12'h967};
    exp_wrap = '{12'h967, 12'h969, 12'h9C9, 12'h7B9, 12'h1B7, 12'h1B1};

    cfg_x = '0;
    for (int k = 0; k < ROWS * COLS; k++) cfg_x[k*8 +: 8] = 8'h24;  // xor(up, up-left)
    cfg_y = '0;
    cfg_y[4*8 +: 8]  = 8'h40;  // cell (1,1) hold, rest pass up
    cfg_y[11*8 +: 8] = 8'h80;  // reserved bit only; makes chain[95]=1, chain[94]=0
    cfg_w = '0;
    cfg_w[6*8 +: 8] = 8'h32;   // cell (2,0) copies left (wraps to col 2)
    cfg_w[2*8 +: 8] = 8'h33;   // cell (0,2) copies right (wraps to col 0)

    // Reset with busy inputs
    reset_n      = 1'b0;
    bus.run      = 1'b1;
    bus.data_in  = '1;
    bus.cfg_en   = 1'b0;
    bus.cfg_in   = 1'b0;
    bus.cfg_load = 1'b0;
    step();
    step();
    check_eq("rst_data_out", 32'(bus.data_out), 32'h0);
    check_eq("rst_cfg_full", 32'(bus.cfg_full), 32'h0);
    check_eq("rst_cfg_err",  32'(bus.cfg_err),  32'h0);
    check_eq("rst_cfg_out",  32'(bus.cfg_out),  32'h0);
    reset_n     = 1'b1;
    bus.data_in = 12'h00A;
    for (int i = 0; i < 3; i++) step();
    check_eq("or_latency_3", 32'(bus.data_out), 32'h000);
    step();
    check_eq("or_latency_4", 32'(bus.data_out), 32'h00A);

    // Early commit: 50 bits shifted, load ignored, error latched
    bus.run = 1'b0;
    for (int i = 0; i < 50; i++) shift_bit(1'b1);
    commit();
    check_eq("early_err",  32'(bus.cfg_err),  32'h1);
    check_eq("early_full", 32'(bus.cfg_full), 32'h0);
    bus.run     = 1'b1;
    bus.data_in = 12'h05A;
    for (int i = 0; i < 3; i++) step();
    check_eq("early_or_3", 32'(bus.data_out), 32'h00A);
    step();
    check_eq("early_or_4", 32'(bus.data_out), 32'h05A);
    bus.data_in = 12'h00A;
    for (int i = 0; i < 4; i++) step();
    check_eq("restore", 32'(bus.data_out), 32'h00A);
    bus.run = 1'b0;
    // Count stayed at 50: full appears on the 96th shift overall
    for (int i = 0; i < 45; i++) shift_bit(1'b0);
    check_eq("full_at_95", 32'(bus.cfg_full), 32'h0);
    shift_bit(1'b0);
    check_eq("full_at_96", 32'(bus.cfg_full), 32'h1);

    // Scan an XOR image (saturated counter keeps shifting) and commit
    load_cfg(cfg_x);
    check_eq("x_full", 32'(bus.cfg_full), 32'h1);
    commit();
    check_eq("x_full_clr", 32'(bus.cfg_full), 32'h0);
    check_eq("x_err_sticky", 32'(bus.cfg_err), 32'h1);
    bus.data_in = 12'h356;
    bus.run     = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("xor_step%0d", i + 1), 32'(bus.data_out), 32'(exp_xor[i]));
    end
    bus.run = 1'b0;

    // Simultaneous commit and shift at full count
    load_cfg(cfg_y);
    check_eq("y_cfg_out_95", 32'(bus.cfg_out), 32'h1);
    bus.cfg_load = 1'b1;
    shift_bit(1'b1);
    bus.cfg_load = 1'b0;
    check_eq("y_full_clr", 32'(bus.cfg_full), 32'h0);
    check_eq("y_cfg_out_94", 32'(bus.cfg_out), 32'h0);

    // Hold / run with the committed pre-shift image
    bus.data_in = 12'h9C7;
    for (int i = 0; i < 5; i++) step();
    check_eq("run0_frozen", 32'(bus.data_out), 32'h635);
    bus.run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("hold_step%0d", i + 1), 32'(bus.data_out), 32'(exp_hold[i]));
    end
    bus.run = 1'b0;

    // Count restarted at 1: full after 95 further shifts
    for (int i = CLEN - 1; i >= 0; i--) begin
      shift_bit(cfg_w[i]);
      if (i == 2) check_eq("w_full_94", 32'(bus.cfg_full), 32'h0);
      if (i == 1) check_eq("w_full_95", 32'(bus.cfg_full), 32'h1);
    end
    commit();
    check_eq("w_err_sticky", 32'(bus.cfg_err), 32'h1);
    bus.data_in = 12'h0B1;
    bus.run     = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("wrap_step%0d", i + 1), 32'(bus.data_out), 32'(exp_wrap[i]));
    end

    // Asynchronous reset in the middle of a shift while running
    for (int i = 0; i < 3; i++) shift_bit(1'b1);
    bus.cfg_en = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_data_out", 32'(bus.data_out), 32'h0);
    check_eq("mid_rst_err",      32'(bus.cfg_err),  32'h0);
    check_eq("mid_rst_full",     32'(bus.cfg_full), 32'h0);
    bus.cfg_en = 1'b0;
    step();
    reset_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
